ram_bus_arbiter: RTL
====================

Name: ram_bus_arbiter

Overview:
Shares the single 16x8 RAM (via MAR and RAM strobes) between two requesters: the CPU fetch/execute path and an external program loader/debug port.
- Sequences every access as a fixed 4-state transaction: address phase, data phase, response.
- Arbitrates with loader priority plus a starvation limit that guarantees CPU progress.
- Sits between the requesters and the mar/ram blocks; it is the only driver of mar_load, ram_read and ram_write.

Parameters:
ADDR_W, 4, RAM address width (matches MAR)
DATA_W, 8, RAM data width (matches BUS)
STARVE_LIMIT, 3, max consecutive loader grants while cpu_req is pending (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_done
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU owns current transaction (ADDR..RESP)
cpu_done  out  1  one-cycle completion pulse
ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader equivalents
ldr_gnt, ldr_done  out  1/1  loader equivalents
rdata  out  DATA_W  read data, valid while *_done is high, held until next read completes
mar_load  out  1  load MAR from mar_addr
mar_addr  out  ADDR_W  address to MAR
ram_read  out  1  RAM read strobe
ram_write  out  1  RAM write strobe
ram_wdata  out  DATA_W  write data to RAM
ram_rdata  in  DATA_W  RAM read data
busy  out  1  state != IDLE
cpu_halt  out  1  see Optional Feature

Behaviour:
- Reset (async, rst=1): state=IDLE, owner=CPU, starve_cnt=0. All outputs are 0, including rdata.
- FSM states: IDLE -> ADDR -> DATA -> RESP -> IDLE. No other transitions. All outputs are registered.
- IDLE: if any request is high at a clock edge, latch owner, we, addr and wdata, then go to ADDR.
- ADDR (1 cycle): mar_load=1, mar_addr=latched addr, owner's gnt=1.
- DATA (1 cycle): ram_read=!we or ram_write=we. ram_wdata=latched wdata. gnt stays high.
- RESP (1 cycle): owner's done=1 and gnt=1. For a read, rdata is captured from ram_rdata at the DATA->RESP edge.
- Latency: request at edge N gives gnt high from N+1 and done in cycle N+3. Throughput is one access per 4 cycles, because IDLE is always re-entered.
- Arbitration in IDLE:
  - Only one requester high: grant it.
  - Both high: grant loader, unless starve_cnt==STARVE_LIMIT, in which case grant CPU.
- starve_cnt:
  - Increments (saturating) on each loader grant while cpu_req=1.
  - Clears on a CPU grant, or on any IDLE cycle with cpu_req=0.
- Latched operands: changes to req/addr/we/wdata after the IDLE latch are ignored.
- Requests dropped mid-transaction: a request deasserted after grant does not abort. The transaction completes and done still pulses.
- Back-to-back requests: a requester holding req high through done is re-arbitrated in the following IDLE cycle.
- Strobe exclusivity: never more than one of mar_load/ram_read/ram_write is high, and never both gnt signals.
- Reset mid-transaction: immediate return to IDLE. No done pulse. Any partially issued write is aborted (strobes drop asynchronously).

Optional Feature:
Macro LOADER_HALT_EN.
- Defined: cpu_halt=1 while ldr_req=1 or owner=loader in a non-IDLE state. The controller uses this to freeze the step counter. Registered, 0 in reset.
- Undefined: cpu_halt is tied to 0 and the related logic is not compiled.

Decomposition:
- Package ram_arb_pkg contains:
  - state typedef {IDLE, ADDR, DATA, RESP}
  - owner typedef {OWN_CPU, OWN_LDR}
  - default ADDR_W/DATA_W constants
- One sub-module, ram_arb_select: combinational winner selection plus the registered starve_cnt. The top holds the FSM and datapath latches.

Test Plan:
- Reset, then CPU read of addr 4h where RAM[4]=8'h2A -> mar_load in cycle 1, ram_read in cycle 2, cpu_done in cycle 3 with rdata=8'h2A.
- Loader write 8'hC3 to addr Fh, then CPU read of Fh -> ram_write once with ram_wdata=8'hC3; CPU read returns 8'hC3.
- Both requesting continuously, STARVE_LIMIT=3 -> grant order LDR,LDR,LDR,CPU,LDR,LDR,LDR,CPU; done pulses never overlap.
- cpu_addr changed from 2h to 7h during ADDR -> mar_addr stays 2h; cpu_done still pulses.
- rst asserted during DATA of a write -> ram_write drops immediately, no done, busy=0; the next request starts cleanly from IDLE.
- With LOADER_HALT_EN defined: ldr_req rises -> cpu_halt=1 next edge, falls the cycle after ldr_done once ldr_req is low. Without the macro, cpu_halt stays 0 throughout.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM bus arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  typedef enum logic       {OWN_CPU, OWN_LDR}       owner_t;

endpackage

// File: rtl/ram_arb_select.sv
// Winner selection between CPU and loader, with loader priority bounded by
// a saturating starvation counter that forces a CPU grant at STARVE_LIMIT.
module ram_arb_select
  import ram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_en,
  input  logic   cpu_req,
  input  logic   ldr_req,
  output logic   win_valid,
  output owner_t win_owner
);

  logic [CNT_W-1:0] starve_cnt;

  // Pick the winner: loader first unless the CPU has waited too long.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win_valid = cpu_req | ldr_req;
    win_owner = OWN_CPU;
    if (ldr_req && !(cpu_req && starve_cnt == CNT_W'(STARVE_LIMIT)))
      win_owner = OWN_LDR;
  end

  // Count consecutive loader grants taken while the CPU is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!cpu_req || win_owner == OWN_CPU)
        starve_cnt <= '0;
      else if (starve_cnt != '1)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares one RAM between the CPU and the program loader. Each access runs
// IDLE -> ADDR -> DATA -> RESP -> IDLE; all outputs are registered.
// Optional macro LOADER_HALT_EN enables the registered cpu_halt output.
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mar_load,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              cpu_halt
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic   arb_en, win_valid, take;
  owner_t win_owner;

  logic              cpu_gnt_d, ldr_gnt_d, cpu_done_d, ldr_done_d;
  logic              mar_load_d, ram_read_d, ram_write_d, busy_d;
  logic [ADDR_W-1:0] mar_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;

  assign arb_en = (state_q == IDLE);
  assign take   = arb_en & win_valid;

  ram_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .cpu_req   (cpu_req),
    .ldr_req   (ldr_req),
    .win_valid (win_valid),
    .win_owner (win_owner)
  );

  // State register.
  // NOTE: sequential logic uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a fixed four-phase walk, leaving IDLE only on a request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = ADDR;
      ADDR:    state_d = DATA;
      DATA:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: the winner's request is frozen in IDLE and held to RESP.
  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (take) begin
      owner_d = win_owner;
      we_d    = (win_owner == OWN_LDR) ? ldr_we    : cpu_we;
      addr_d  = (win_owner == OWN_LDR) ? ldr_addr  : cpu_addr;
      wdata_d = (win_owner == OWN_LDR) ? ldr_wdata : cpu_wdata;
    end
  end

  // Operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Output decode from the upcoming state, so the flops present it in that state.
  always_comb begin
    cpu_gnt_d   = 1'b0;
    ldr_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    ldr_done_d  = 1'b0;
    mar_load_d  = 1'b0;
    mar_addr_d  = '0;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_wdata_d = '0;
    busy_d      = (state_d != IDLE);
    if (state_d != IDLE) begin
      cpu_gnt_d = (owner_d == OWN_CPU);
      ldr_gnt_d = (owner_d == OWN_LDR);
    end
    case (state_d)
      ADDR: begin
        mar_load_d = 1'b1;
        mar_addr_d = addr_d;
      end
      DATA: begin
        ram_read_d  = !we_d;
        ram_write_d = we_d;
        ram_wdata_d = wdata_d;
      end
      RESP: begin
        cpu_done_d = (owner_d == OWN_CPU);
        ldr_done_d = (owner_d == OWN_LDR);
      end
      default: ;
    endcase
  end

  // Output registers; read data is taken on the DATA->RESP edge and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_gnt   <= 1'b0;
      ldr_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      ldr_done  <= 1'b0;
      mar_load  <= 1'b0;
      mar_addr  <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      rdata     <= '0;
    end else begin
      cpu_gnt   <= cpu_gnt_d;
      ldr_gnt   <= ldr_gnt_d;
      cpu_done  <= cpu_done_d;
      ldr_done  <= ldr_done_d;
      mar_load  <= mar_load_d;
      mar_addr  <= mar_addr_d;
      ram_read  <= ram_read_d;
      ram_write <= ram_write_d;
      ram_wdata <= ram_wdata_d;
      busy      <= busy_d;
      if (state_q == DATA && !we_q) rdata <= ram_rdata;
    end
  end

`ifdef LOADER_HALT_EN
  // Freeze the CPU while the loader is asking for or holding the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cpu_halt <= 1'b0;
    else     cpu_halt <= ldr_req | (state_d != IDLE && owner_d == OWN_LDR);
  end
`else
  assign cpu_halt = 1'b0;
`endif

endmodule
